// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Shifts in a fixed-length serial frame, MSB first, after a one-cycle start_det
//   pulse from the upstream start-nibble detector. The frame is presented as a
//   parallel word on a valid/ready interface. A completed frame that finds the
//   output still occupied is dropped and flagged with ovr_err.
//
//   Optional feature: define SERIAL_FRAME_RX_PARITY_EN to append one even-parity
//   bit after the data (extra PAR state). A bad parity bit drops the frame and
//   pulses par_err. With the macro undefined, par_err is tied low.
module serial_frame_rx #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sIn,
    input  logic              start_det,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              ovr_err,
    output logic              par_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              ovr_q;

    logic              last_bit;
    logic              complete;
    logic              word_good;
    logic              accept;
    logic [DATA_W-1:0] word;

`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic              par_q;
`endif

    // Next shift value, completion/acceptance conditions and candidate word
    always_comb begin
        shreg_d  = {shreg_q[DATA_W-2:0], sIn};
        last_bit = (state_q == SHIFT) && (cnt_q == CNT_W'(DATA_W - 1));
        accept   = out_valid_q && out_ready;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        // The parity bit is on sIn at the PAR edge; the data is already complete
        // in shreg_q, so the word is taken from there rather than the shifted value.
        complete  = (state_q == PAR);
        word      = shreg_q;
        word_good = ~(^{shreg_q, sIn});
`else
        // The word completes on the edge that samples its last bit, so the
        // loaded value is the shift register including the bit on sIn now.
        complete  = last_bit;
        word      = shreg_d;
        word_good = 1'b1;
`endif
    end

    // Frame FSM, bit counter, shift register and registered output interface
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovr_q       <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            ovr_q <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_q <= 1'b0;
`endif

            case (state_q)
                IDLE: begin
                    if (start_det) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                    end
                end

                SHIFT: begin
                    // start_det is ignored here: no restart mid-frame
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state_q <= PAR;
`else
                        // A start on the completion edge chains straight into the next frame
                        if (start_det) begin
                            state_q <= SHIFT;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
`endif
                    end
                end

`ifdef SERIAL_FRAME_RX_PARITY_EN
                PAR: begin
                    if (start_det) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
`endif

                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Output word handling: a good completion either loads (slot free or
            // being drained this edge) or overruns; a bad one only flags parity.
            if (complete && word_good) begin
                if (out_valid_q && !out_ready) begin
                    ovr_q <= 1'b1;
                end else begin
                    out_data_q  <= word;
                    out_valid_q <= 1'b1;
                end
            end else begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                if (complete) begin
                    par_q <= 1'b1;
                end
`endif
                if (accept) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign ovr_err   = ovr_q;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    assign par_err   = par_q;
`else
    assign par_err   = 1'b0;
`endif

    // A held word stays put until the consumer takes it
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_data_q)));

    // The bit counter never runs past the last data bit
    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        (state_q == SHIFT) |-> (cnt_q <= CNT_W'(DATA_W - 1)));

    // Error pulses are mutually exclusive
    a_err_excl: assert property (@(posedge clk) disable iff (rst)
        !(ovr_err && par_err));

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx (DATA_W = 16). Expected words are
// queued when a frame is driven and popped when the consumer takes them.
module tb_serial_frame_rx;

    localparam int DW = 16;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam bit PB = 1'b1;
`else
    localparam bit PB = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          sIn;
    logic          start_det;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          ovr_err;
    logic          par_err;

    int checks;
    int failures;

    logic [DW-1:0] exp_q[$];

    serial_frame_rx #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sIn       (sIn),
        .start_det (start_det),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .ovr_err   (ovr_err),
        .par_err   (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    // Drive one frame. The final edge (last data bit, or parity bit) carries
    // start_det=chain and out_ready=rdy_last; returns #1 after that edge.
    task automatic send_frame(input logic [DW-1:0] d, input bit with_start,
                              input bit chain, input bit bad_par, input logic rdy_last);
        logic [DW-1:0] w;
        w = d;
        if (with_start) begin
            start_det = 1'b1;
            tick();
        end
        start_det = 1'b0;
        for (int i = DW - 1; i >= 0; i--) begin
            sIn = w[i];
            if (i == 0 && !PB) begin
                start_det = chain;
                out_ready = rdy_last;
            end
            tick();
        end
        if (PB) begin
            sIn       = (^w) ^ bad_par;
            start_det = chain;
            out_ready = rdy_last;
            tick();
        end
        start_det = 1'b0;
        sIn       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sIn = ~sIn;
            tick();
        end
        sIn = ~sIn;
        checks++; if (out_data !== '0)    begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ovr_err !== 1'b0)   begin failures++; $display("FAIL reset_ovr got=%b exp=0", ovr_err); end
        checks++; if (par_err !== 1'b0)   begin failures++; $display("FAIL reset_par got=%b exp=0", par_err); end
        rst = 1'b0;
        sIn = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [DW-1:0] w;
        logic [DW-1:0] e;
        int lat;
        bit seen;
        w = 16'hA5C3;
        exp_q.push_back(w);
        out_ready = 1'b1;
        start_det = 1'b1;
        tick();
        start_det = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (i < DW)                 sIn = w[DW-1-i];
            else if (PB && i == DW)     sIn = ^w;
            else                        sIn = 1'b0;
            tick();
            lat = i + 1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        sIn = 1'b0;
        checks++; if (!seen) begin failures++; $display("FAIL basic_timeout got=no_valid exp=valid"); end
        checks++; if (lat != DW + int'(PB)) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, DW + int'(PB)); end
        e = pop_exp();
        checks++; if (out_data !== e) begin failures++; $display("FAIL basic_data got=%h exp=%h", out_data, e); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", busy); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_onecycle got=%b exp=0", out_valid); end
    endtask

    task automatic test_overrun();
        logic [DW-1:0] e;
        out_ready = 1'b0;
        exp_q.push_back(16'h1234);
        send_frame(16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovr_first_valid got=%b exp=1", out_valid); end
        checks++; if (ovr_err !== 1'b0) begin failures++; $display("FAIL ovr_first_noerr got=%b exp=0", ovr_err); end
        send_frame(16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (ovr_err !== 1'b1) begin failures++; $display("FAIL ovr_pulse got=%b exp=1", ovr_err); end
        checks++; if (out_data !== 16'h1234) begin failures++; $display("FAIL ovr_hold_data got=%h exp=1234", out_data); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovr_hold_valid got=%b exp=1", out_valid); end
        tick();
        checks++; if (ovr_err !== 1'b0) begin failures++; $display("FAIL ovr_pulse_width got=%b exp=0", ovr_err); end
        e = pop_exp();
        checks++; if (out_data !== e) begin failures++; $display("FAIL ovr_accept_data got=%h exp=%h", out_data, e); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        out_ready = 1'b0;
        exp_q.push_back(16'h00FF);
        exp_q.push_back(16'hFF00);
        send_frame(16'h00FF, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got=%b exp=1", out_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_chain_busy got=%b exp=1", busy); end
        e = pop_exp();
        checks++; if (out_data !== e) begin failures++; $display("FAIL b2b_first_data got=%h exp=%h", out_data, e); end
        send_frame(16'hFF00, 1'b0, 1'b0, 1'b0, 1'b1);
        e = pop_exp();
        checks++; if (out_data !== e) begin failures++; $display("FAIL b2b_second_data got=%h exp=%h", out_data, e); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_second_valid got=%b exp=1", out_valid); end
        checks++; if (ovr_err !== 1'b0) begin failures++; $display("FAIL b2b_no_ovr got=%b exp=0", ovr_err); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_abort();
        logic [DW-1:0] w;
        logic [DW-1:0] e;
        out_ready = 1'b0;
        send_frame(16'h5A5A, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL abort_held got=%b exp=1", out_valid); end
        w = 16'hC3C3;
        start_det = 1'b1;
        tick();
        start_det = 1'b0;
        for (int i = 0; i < 7; i++) begin
            sIn = w[DW-1-i];
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b exp=0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL abort_data got=%h exp=0", out_data); end
        out_ready = 1'b1;
        exp_q.push_back(16'h0F0F);
        send_frame(16'h0F0F, 1'b1, 1'b0, 1'b0, 1'b1);
        e = pop_exp();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL abort_next_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== e) begin failures++; $display("FAIL abort_next_data got=%h exp=%h", out_data, e); end
        tick();
    endtask

    task automatic test_random();
        logic [DW-1:0] w;
        logic [DW-1:0] e;
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            w = DW'($urandom);
            exp_q.push_back(w);
            send_frame(w, 1'b1, 1'b0, 1'b0, 1'b1);
            e = pop_exp();
            checks++; if (out_valid !== 1'b1 || out_data !== e) begin
                failures++; $display("FAIL rand_word%0d got=%b/%h exp=1/%h", n, out_valid, out_data, e);
            end
            tick();
        end
    endtask

`ifdef SERIAL_FRAME_RX_PARITY_EN
    task automatic test_parity();
        logic [DW-1:0] e;
        out_ready = 1'b0;
        exp_q.push_back(16'h0001);
        send_frame(16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || par_err !== 1'b0) begin
            failures++; $display("FAIL par_good got=%b/%b exp=1/0", out_valid, par_err);
        end
        send_frame(16'h0001, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++; if (par_err !== 1'b1) begin failures++; $display("FAIL par_pulse got=%b exp=1", par_err); end
        checks++; if (ovr_err !== 1'b0) begin failures++; $display("FAIL par_no_ovr got=%b exp=0", ovr_err); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL par_valid_kept got=%b exp=1", out_valid); end
        tick();
        checks++; if (par_err !== 1'b0) begin failures++; $display("FAIL par_pulse_width got=%b exp=0", par_err); end
        e = pop_exp();
        checks++; if (out_data !== e) begin failures++; $display("FAIL par_data got=%h exp=%h", out_data, e); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL par_drain got=%b exp=0", out_valid); end
    endtask
`endif

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        sIn       = 1'b0;
        start_det = 1'b0;
        out_ready = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_abort();
        test_random();
`ifdef SERIAL_FRAME_RX_PARITY_EN
        test_parity();
`endif
        checks++; if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_empty got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
